// File: rtl/xor_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xor_mux_pkg
//  Description : Shared constants and select encoding for the mux-only
//                XOR datapath cell.
//  Revision    : 1.0 - initial release
// ============================================================================
package xor_mux_pkg;

    // Widest operand the cell is characterised for
    localparam int MAX_WIDTH = 64;

    // Meaning of a 2:1 mux select in the XOR cell: pass the operand or
    // pass its inverse
    typedef enum logic {
        SEL_PASS = 1'b0,
        SEL_INV  = 1'b1
    } sel_e;

endpackage : xor_mux_pkg
`default_nettype wire

// File: rtl/xor_mux_gate_mux2.sv
`default_nettype none
// ============================================================================
//  Module      : mux2
//  Description : 1-bit 2:1 multiplexer, the only gate used to build the
//                XOR datapath and its parity chain.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux2
    import xor_mux_pkg::*;
(
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);

    // Select the inverted leg when sel carries the SEL_INV encoding
    assign y = (sel_e'(sel) == SEL_INV) ? d1 : d0;

endmodule : mux2
`default_nettype wire

// File: rtl/xor_mux_gate.sv
`default_nettype none
// ============================================================================
//  Module      : xor_mux_gate
//  Description : Bitwise a XOR b built purely from 2:1 muxes, with a
//                combinational result and a one-cycle registered result
//                qualified by out_valid.
//                Optional macro XOR_MUX_PARITY_EN adds a registered parity
//                output (reduction XOR of y_comb, also built from muxes).
//  Revision    : 1.0 - initial release
// ============================================================================
module xor_mux_gate
    import xor_mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y_comb,
    output logic [WIDTH-1:0] y,
    output logic             out_valid
`ifdef XOR_MUX_PARITY_EN
    ,
    output logic             parity
`endif
);

    logic [WIDTH-1:0] w_not_a;
    logic [WIDTH-1:0] w_xor;
    logic [WIDTH-1:0] r_y;
    logic             r_out_valid;

    assign w_not_a = ~a;

    // One mux per bit: b[i] chooses between a[i] and ~a[i]
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            mux2 u_mux (
                .d0  (a[gi]),
                .d1  (w_not_a[gi]),
                .sel (b[gi]),
                .y   (w_xor[gi])
            );
        end
    endgenerate

    assign y_comb    = w_xor;
    assign y         = r_y;
    assign out_valid = r_out_valid;

    // Capture the result on in_valid; y holds otherwise, valid tracks in_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_y <= w_xor;
            end
        end
    end

`ifdef XOR_MUX_PARITY_EN
    logic [WIDTH-1:0] w_par_chain;
    logic             r_parity;

    // Chain head is bit 0; each later bit conditionally inverts the running parity
    assign w_par_chain[0] = w_xor[0];

    genvar gp;
    generate
        for (gp = 1; gp < WIDTH; gp++) begin : g_parity
            mux2 u_pmux (
                .d0  (w_par_chain[gp-1]),
                .d1  (~w_par_chain[gp-1]),
                .sel (w_xor[gp]),
                .y   (w_par_chain[gp])
            );
        end
    endgenerate

    assign parity = r_parity;

    // Parity register follows the same capture/hold rule as y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (in_valid) begin
            r_parity <= w_par_chain[WIDTH-1];
        end
    end
`else
    // Parity output and its mux chain are not built in this configuration
`endif

endmodule : xor_mux_gate
`default_nettype wire

// File: tb/tb_xor_mux_gate.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xor_mux_gate
//  Description : Scoreboard bench for xor_mux_gate at WIDTH=1 and WIDTH=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_mux_gate;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [0:0] a1, b1, yc1, y1;
    logic       v1, ov1;
    logic [7:0] a8, b8, yc8, y8;
    logic       v8, ov8;
`ifdef XOR_MUX_PARITY_EN
    logic       par1, par8;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int         due;
        logic [7:0] y;
        logic       p;
    } exp_t;

    exp_t q1[$];
    exp_t q8[$];

    xor_mux_gate #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a1),
        .b         (b1),
        .in_valid  (v1),
        .y_comb    (yc1),
        .y         (y1),
        .out_valid (ov1)
`ifdef XOR_MUX_PARITY_EN
        ,
        .parity    (par1)
`endif
    );

    xor_mux_gate #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a8),
        .b         (b8),
        .in_valid  (v8),
        .y_comb    (yc8),
        .y         (y8),
        .out_valid (ov8)
`ifdef XOR_MUX_PARITY_EN
        ,
        .parity    (par8)
`endif
    );

    // Cycle stamp used to tell when a queued result is due
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for the 8-bit instance
    always @(negedge clk) begin
        if (q8.size() > 0 && q8[0].due == cyc) begin
            chk("w8_out_valid", {7'b0, ov8}, 8'h01);
            chk("w8_y", y8, q8[0].y);
`ifdef XOR_MUX_PARITY_EN
            chk("w8_parity", {7'b0, par8}, {7'b0, q8[0].p});
`endif
            void'(q8.pop_front());
        end else begin
            chk("w8_idle_out_valid", {7'b0, ov8}, 8'h00);
        end
    end

    // Monitor for the 1-bit instance
    always @(negedge clk) begin
        if (q1.size() > 0 && q1[0].due == cyc) begin
            chk("w1_out_valid", {7'b0, ov1}, 8'h01);
            chk("w1_y", {7'b0, y1}, q1[0].y);
`ifdef XOR_MUX_PARITY_EN
            chk("w1_parity", {7'b0, par1}, {7'b0, q1[0].p});
`endif
            void'(q1.pop_front());
        end else begin
            chk("w1_idle_out_valid", {7'b0, ov1}, 8'h00);
        end
    end

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic v,
                          input logic [7:0] exp, input logic exp_p);
        exp_t e;
        @(posedge clk);
        #2;
        a8 = a;
        b8 = b;
        v8 = v;
        if (v) begin
            e.due = cyc + 1;
            e.y   = exp;
            e.p   = exp_p;
            q8.push_back(e);
        end
        #1 chk("w8_y_comb", yc8, exp);
    endtask

    task automatic drive1(input logic a, input logic b, input logic v, input logic exp);
        exp_t e;
        @(posedge clk);
        #2;
        a1 = a;
        b1 = b;
        v1 = v;
        if (v) begin
            e.due = cyc + 1;
            e.y   = {7'b0, exp};
            e.p   = exp;
            q1.push_back(e);
        end
        #1 chk("w1_y_comb", {7'b0, yc1}, {7'b0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra, rb;
        a1 = '0; b1 = '0; v1 = 1'b0;
        a8 = '0; b8 = '0; v8 = 1'b0;

        // Reset state
        #1;
        chk("rst_w8_y", y8, 8'h00);
        chk("rst_w8_ov", {7'b0, ov8}, 8'h00);
        chk("rst_w1_y", {7'b0, y1}, 8'h00);
        chk("rst_w1_ov", {7'b0, ov1}, 8'h00);
        #12 rst_n = 1'b1;

        // WIDTH=1 truth table
        drive1(1'b0, 1'b0, 1'b1, 1'b0);
        drive1(1'b0, 1'b1, 1'b1, 1'b1);
        drive1(1'b1, 1'b0, 1'b1, 1'b1);
        drive1(1'b1, 1'b1, 1'b1, 1'b0);
        drive1(1'b0, 1'b0, 1'b0, 1'b0);

        // WIDTH=8 basic vector
        drive8(8'hA5, 8'h0F, 1'b1, 8'hAA, 1'b0);

        // Hold with in_valid low
        drive8(8'hFF, 8'h00, 1'b1, 8'hFF, 1'b0);
        drive8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #2;
        chk("hold_y", y8, 8'hFF);
        chk("hold_y_comb", yc8, 8'h00);
        chk("hold_ov", {7'b0, ov8}, 8'h00);

        // Asynchronous reset between edges, while a result is presented
        drive8(8'h3C, 8'h00, 1'b1, 8'h3C, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_rst_y", y8, 8'h3C);
        chk("pre_rst_ov", {7'b0, ov8}, 8'h01);
        q8.delete();
        v8 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_y", y8, 8'h00);
        chk("async_rst_ov", {7'b0, ov8}, 8'h00);
        @(posedge clk);
        #3;
        chk("in_rst_y", y8, 8'h00);
        rst_n = 1'b1;
        drive8(8'h01, 8'h03, 1'b1, 8'h02, 1'b1);

        // Back-to-back random operands
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            drive8(ra, rb, 1'b1, ra ^ rb, ^(ra ^ rb));
        end

        // Parity vectors
        drive8(8'h07, 8'h00, 1'b1, 8'h07, 1'b1);
        drive8(8'h03, 8'h00, 1'b1, 8'h03, 1'b0);
        drive8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        chk("q8_drained", 8'(q8.size()), 8'h00);
        chk("q1_drained", 8'(q1.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_xor_mux_gate
`default_nettype wire
